// File: rtl/mbus_int_pkg.sv
// mbus_int_pkg
//   Shared defaults and width helpers for the bus toggle interrupt detector.
//   DEF_TOGGLE_CNT  : data edges within one qualifying clock phase that raise an interrupt
//   DEF_SYNC_STAGES : synchroniser depth applied to each asynchronous bus input
//   cnt_width()     : width of a per-channel edge counter able to hold toggle_cnt
//   idx_width()     : width of the channel index output (at least 1 bit)
package mbus_int_pkg;

   localparam int unsigned DEF_TOGGLE_CNT  = 6;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   function automatic int unsigned cnt_width(input int unsigned toggle_cnt);
      return $clog2(toggle_cnt + 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/mbus_int_detector_ch.sv
// mbus_int_detector_ch
//   One monitored bus channel: synchronises BUS_CLK/BUS_DATA, detects data
//   edges, counts them while the bus clock sits at the qualifying level and
//   raises a sticky interrupt once TOGGLE_CNT edges have been seen.
//   CLK, RESET : system clock, asynchronous active-high reset
//   BUS_CLK    : asynchronous bus clock line
//   BUS_DATA   : asynchronous bus data line
//   CLK_PHASE  : bus clock level during which edges are counted (quasi-static)
//   CH_EN      : channel enable; low holds the counter at zero
//   INT_CLR    : one-cycle flag clear
//   INT_FLAG   : sticky interrupt flag
//   LAST_CLK   : synchronised bus clock level captured when the flag was set
module mbus_int_detector_ch
   import mbus_int_pkg::*;
#(
   parameter int unsigned TOGGLE_CNT  = DEF_TOGGLE_CNT,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic CLK,
   input  logic RESET,
   input  logic BUS_CLK,
   input  logic BUS_DATA,
   input  logic CLK_PHASE,
   input  logic CH_EN,
   input  logic INT_CLR,
   output logic INT_FLAG,
   output logic LAST_CLK
);

   localparam int unsigned     CW      = cnt_width(TOGGLE_CNT);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TOGGLE_CNT);
   localparam logic [CW-1:0]   CNT_PRE = CW'(TOGGLE_CNT - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   data_dly;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   clk_s;
   logic                   data_s;
   logic                   qual;
   logic                   data_edge;
   logic                   trigger;

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         clk_sync  <= '0;
         data_sync <= '0;
         data_dly  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], BUS_CLK};
         data_sync <= {data_sync[SYNC_STAGES-2:0], BUS_DATA};
         data_dly  <= data_s;
      end
   end

   // Leaving the qualifying phase (or disabling) clears the count and
   // overrides any data edge arriving in the same cycle.
   always_comb begin
      qual      = CH_EN && (clk_s == CLK_PHASE);
      data_edge = data_s ^ data_dly;
      trigger   = qual && data_edge && (cnt == CNT_PRE);
      cnt_nxt   = cnt;
      if (!qual)
         cnt_nxt = '0;
      else if (data_edge && (cnt != CNT_MAX))
         cnt_nxt = cnt + CNT_ONE;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   // A trigger takes precedence over a clear issued in the same cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         INT_FLAG <= 1'b0;
         LAST_CLK <= 1'b0;
      end else if (trigger) begin
         INT_FLAG <= 1'b1;
         LAST_CLK <= clk_s;
      end else if (INT_CLR) begin
         INT_FLAG <= 1'b0;
      end
   end

endmodule

// File: rtl/mbus_int_detector.sv
// mbus_int_detector
//   Multi-channel bus toggle interrupt detector. Each channel is an
//   independent mbus_int_detector_ch; the top adds a lowest-index priority
//   encoder over the flags.
//   CLK, RESET : system clock, asynchronous active-high reset
//   BUS_CLK    : [NUM_CH] asynchronous bus clock lines
//   BUS_DATA   : [NUM_CH] asynchronous bus data lines
//   CLK_PHASE  : [NUM_CH] qualifying bus clock level per channel
//   CH_EN      : [NUM_CH] channel enables
//   INT_CLR    : [NUM_CH] one-cycle flag clears
//   INT_FLAG   : [NUM_CH] sticky interrupt flags
//   LAST_CLK   : [NUM_CH] bus clock level captured at each trigger
//   INT_ANY    : OR of all flags
//   INT_CH     : index of the lowest-numbered set flag, 0 when none
module mbus_int_detector
   import mbus_int_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 1,
   parameter  int unsigned TOGGLE_CNT  = DEF_TOGGLE_CNT,
   parameter  int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   localparam int unsigned CHW         = idx_width(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] BUS_CLK,
   input  logic [NUM_CH-1:0] BUS_DATA,
   input  logic [NUM_CH-1:0] CLK_PHASE,
   input  logic [NUM_CH-1:0] CH_EN,
   input  logic [NUM_CH-1:0] INT_CLR,
   output logic [NUM_CH-1:0] INT_FLAG,
   output logic [NUM_CH-1:0] LAST_CLK,
   output logic              INT_ANY,
   output logic [CHW-1:0]    INT_CH
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      mbus_int_detector_ch #(
         .TOGGLE_CNT  (TOGGLE_CNT),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .CLK       (CLK),
         .RESET     (RESET),
         .BUS_CLK   (BUS_CLK[g]),
         .BUS_DATA  (BUS_DATA[g]),
         .CLK_PHASE (CLK_PHASE[g]),
         .CH_EN     (CH_EN[g]),
         .INT_CLR   (INT_CLR[g]),
         .INT_FLAG  (INT_FLAG[g]),
         .LAST_CLK  (LAST_CLK[g])
      );
   end

   // Scan from the top down so the lowest set index is written last.
   always_comb begin
      INT_ANY = |INT_FLAG;
      INT_CH  = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (INT_FLAG[i-1])
            INT_CH = CHW'(i - 1);
      end
   end

endmodule

// File: tb/tb_mbus_int_detector.sv
// tb_mbus_int_detector
//   Directed scenarios plus randomized traffic on a two-channel detector.
//   A reference model updated at every rising edge pushes the expected
//   outputs into a queue; a monitor on the falling edge pops and compares.
//   Scenario checks against fixed values are made at points of interest.
module tb_mbus_int_detector;

   localparam int unsigned NCH = 2;
   localparam int unsigned TC  = 6;
   localparam int unsigned SS  = 2;

   logic           CLK = 1'b0;
   logic           RESET = 1'b1;
   logic [NCH-1:0] BUS_CLK = '0;
   logic [NCH-1:0] BUS_DATA = '0;
   logic [NCH-1:0] CLK_PHASE = '1;
   logic [NCH-1:0] CH_EN = '1;
   logic [NCH-1:0] INT_CLR = '0;
   logic [NCH-1:0] INT_FLAG;
   logic [NCH-1:0] LAST_CLK;
   logic           INT_ANY;
   logic [0:0]     INT_CH;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [NCH-1:0] flag;
      logic [NCH-1:0] last;
      logic           any;
      logic           ch;
   } exp_t;

   exp_t exp_q[$];

   mbus_int_detector #(
      .NUM_CH      (NCH),
      .TOGGLE_CNT  (TC),
      .SYNC_STAGES (SS)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .BUS_CLK   (BUS_CLK),
      .BUS_DATA  (BUS_DATA),
      .CLK_PHASE (CLK_PHASE),
      .CH_EN     (CH_EN),
      .INT_CLR   (INT_CLR),
      .INT_FLAG  (INT_FLAG),
      .LAST_CLK  (LAST_CLK),
      .INT_ANY   (INT_ANY),
      .INT_CH    (INT_CH)
   );

   always #5 CLK = ~CLK;

   // Reference model: each input is seen by the counting logic SS cycles
   // after it is sampled; a data edge is a change between consecutive
   // seen values. Edges are counted per qualifying phase run.
   initial begin
      logic [SS+1:0]  h_clk [NCH];
      logic [SS+1:0]  h_dat [NCH];
      int             m_cnt [NCH];
      logic [NCH-1:0] m_flag;
      logic [NCH-1:0] m_last;
      logic           sc;
      logic           ed;
      logic           trig;
      exp_t           e;
      m_flag = '0;
      m_last = '0;
      for (int c = 0; c < NCH; c++) begin
         h_clk[c] = '0;
         h_dat[c] = '0;
         m_cnt[c] = 0;
      end
      forever begin
         @(posedge CLK);
         if (RESET) begin
            m_flag = '0;
            m_last = '0;
            for (int c = 0; c < NCH; c++) begin
               h_clk[c] = '0;
               h_dat[c] = '0;
               m_cnt[c] = 0;
            end
         end else begin
            for (int c = 0; c < NCH; c++) begin
               h_clk[c] = {h_clk[c][SS:0], BUS_CLK[c]};
               h_dat[c] = {h_dat[c][SS:0], BUS_DATA[c]};
               sc   = h_clk[c][SS];
               ed   = h_dat[c][SS] != h_dat[c][SS+1];
               trig = 1'b0;
               if (!(CH_EN[c] && (sc == CLK_PHASE[c]))) begin
                  m_cnt[c] = 0;
               end else if (ed && (m_cnt[c] < TC)) begin
                  m_cnt[c] = m_cnt[c] + 1;
                  if (m_cnt[c] == TC) trig = 1'b1;
               end
               if (trig) begin
                  m_flag[c] = 1'b1;
                  m_last[c] = sc;
               end else if (INT_CLR[c]) begin
                  m_flag[c] = 1'b0;
               end
            end
         end
         e.flag = m_flag;
         e.last = m_last;
         e.any  = (m_flag != '0);
         e.ch   = (m_flag[0] || (m_flag == '0)) ? 1'b0 : 1'b1;
         exp_q.push_back(e);
      end
   end

   // Monitor: outputs are presented every cycle; compare away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({INT_FLAG, LAST_CLK, INT_ANY, INT_CH} !== {e.flag, e.last, e.any, e.ch}) begin
               failures++;
               $display("FAIL sb t=%0t act flag=%b last=%b any=%b ch=%0d req flag=%b last=%b any=%b ch=%0d",
                        $time, INT_FLAG, LAST_CLK, INT_ANY, INT_CH, e.flag, e.last, e.any, e.ch);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t act=%0h req=%0h", nm, $time, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic tog(input int c, input int n, input int gap);
      repeat (n) begin
         BUS_DATA[c] = ~BUS_DATA[c];
         step(gap);
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog t=%0t act=running req=finished", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_flag", 8'(INT_FLAG), 8'h0);
      chk("rst_any",  8'(INT_ANY), 8'h0);
      step(3);
      @(negedge CLK); #1;
      RESET = 1'b0;
      CLK_PHASE = 2'b11;
      CH_EN = 2'b11;
      BUS_CLK = 2'b01;
      step(4);

      // Channel 0: six toggles in the high phase, check exact latency
      tog(0, 5, 8);
      BUS_DATA[0] = ~BUS_DATA[0];
      step(2);
      chk("lat_early", 8'(INT_FLAG[0]), 8'h0);
      step(1);
      chk("lat_flag",  8'(INT_FLAG[0]), 8'h1);
      chk("lat_last",  8'(LAST_CLK[0]), 8'h1);
      chk("lat_ch",    8'(INT_CH), 8'h0);
      chk("lat_any",   8'(INT_ANY), 8'h1);

      // Channel 1: five toggles, phase exit, one toggle -> no flag
      BUS_CLK[1] = 1'b1; step(4);
      tog(1, 5, 4);
      BUS_CLK[1] = 1'b0; step(4);
      BUS_CLK[1] = 1'b1; step(4);
      tog(1, 1, 4);
      step(6);
      chk("exit_noflag", 8'(INT_FLAG[1]), 8'h0);

      // Both triggered, then clear channel 0
      BUS_CLK[1] = 1'b0; step(4);
      BUS_CLK[1] = 1'b1; step(4);
      tog(1, 6, 4);
      step(4);
      chk("both_flag", 8'(INT_FLAG), 8'h3);
      INT_CLR = 2'b01; step(1); INT_CLR = 2'b00;
      chk("clr_flag", 8'(INT_FLAG), 8'h2);
      chk("clr_ch",   8'(INT_CH), 8'h1);
      chk("clr_any",  8'(INT_ANY), 8'h1);
      chk("clr_last", 8'(LAST_CLK[0]), 8'h1);

      // Clear on the triggering edge: set wins
      BUS_CLK[0] = 1'b0; step(4);
      BUS_CLK[0] = 1'b1; step(4);
      tog(0, 5, 4);
      BUS_DATA[0] = ~BUS_DATA[0];
      step(2);
      chk("setwin_pre", 8'(INT_FLAG[0]), 8'h0);
      INT_CLR = 2'b01; step(1); INT_CLR = 2'b00;
      chk("setwin", 8'(INT_FLAG[0]), 8'h1);

      // Disabled channel: no new trigger, existing flag kept
      CH_EN[0] = 1'b0;
      tog(0, 10, 3);
      chk("dis_keep", 8'(INT_FLAG[0]), 8'h1);
      INT_CLR = 2'b01; step(1); INT_CLR = 2'b00;
      tog(0, 10, 3);
      chk("dis_noflag", 8'(INT_FLAG[0]), 8'h0);
      CH_EN[0] = 1'b1;
      step(4);

      // Low qualifying phase
      CLK_PHASE[0] = 1'b0;
      BUS_CLK[0] = 1'b0;
      step(4);
      tog(0, 6, 4);
      chk("low_flag", 8'(INT_FLAG[0]), 8'h1);
      chk("low_last", 8'(LAST_CLK[0]), 8'h0);
      INT_CLR = 2'b01; step(1); INT_CLR = 2'b00;
      BUS_CLK[0] = 1'b1; step(4);
      BUS_CLK[0] = 1'b0; step(4);
      tog(0, 4, 4);
      chk("pre_rst_last", 8'(LAST_CLK), 8'h2);

      // Reset mid-sequence
      @(negedge CLK); #1;
      RESET = 1'b1;
      #1;
      chk("arst_flag", 8'(INT_FLAG), 8'h0);
      chk("arst_last", 8'(LAST_CLK), 8'h0);
      chk("arst_any",  8'(INT_ANY), 8'h0);
      chk("arst_ch",   8'(INT_CH), 8'h0);
      repeat (3) @(negedge CLK);
      #1;
      RESET = 1'b0;
      step(1);
      tog(0, 2, 4);
      step(8);
      chk("post_rst_noflag", 8'(INT_FLAG[0]), 8'h0);

      // Randomized traffic
      repeat (3000) begin
         for (int c = 0; c < NCH; c++) begin
            if (($urandom % 2) != 0) BUS_DATA[c] = ~BUS_DATA[c];
            if (($urandom % 12) == 0) BUS_CLK[c] = ~BUS_CLK[c];
            CH_EN[c]   = ($urandom % 32) != 0;
            INT_CLR[c] = ($urandom % 24) == 0;
            if (($urandom % 400) == 0) CLK_PHASE[c] = ~CLK_PHASE[c];
         end
         step(1);
      end
      INT_CLR = '0;
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
